// File: rtl/sine_freq_meter.sv
// Sine frequency meter: counts hysteresis-qualified rising crossings
// and tracks period and peaks over a gated measurement window.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     in_sample qualifier
//   in_sample    signed 8-bit sample under measurement
//   start        request a new window (honoured in IDLE only)
//   busy         window in progress (MEASURE or DONE)
//   done         one-cycle pulse, results valid
//   crossings    rising crossings in last window (saturating)
//   last_period  cycles between the last two crossings, else 0
//   peak_max     largest valid sample of last window
//   peak_min     smallest valid sample of last window
//   no_signal    fewer than two crossings in last window
module sine_freq_meter #(
  parameter int unsigned GATE_CYCLES = 1_000_000,
  parameter int unsigned HYST        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic signed [7:0] in_sample,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       crossings,
  output logic [31:0]       last_period,
  output logic signed [7:0] peak_max,
  output logic signed [7:0] peak_min,
  output logic              no_signal
);

  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic signed [7:0] HI_TH = 8'(HYST);
  localparam logic signed [7:0] LO_TH = -HI_TH;
  localparam logic signed [7:0] MAX_INIT = -8'sd128;
  localparam logic signed [7:0] MIN_INIT = 8'sd127;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]       r_gate_cnt;
  logic [31:0]       r_cnt;
  logic              r_armed;
  logic [31:0]       r_ts_last;
  logic [31:0]       r_ts_prev;
  logic [1:0]        r_ts_nv;
  logic signed [7:0] r_max;
  logic signed [7:0] r_min;

  logic [31:0]       r_crossings;
  logic [31:0]       r_last_period;
  logic signed [7:0] r_peak_max;
  logic signed [7:0] r_peak_min;
  logic              r_no_signal;

  logic              w_measure;
  logic              w_gate_last;
  logic              w_proc;
  logic              w_low;
  logic              w_high;
  logic              w_cross;
  logic [31:0]       w_cnt_nx;
  logic              w_armed_nx;
  logic [31:0]       w_last_nx;
  logic [31:0]       w_prev_nx;
  logic [1:0]        w_nv_nx;
  logic signed [7:0] w_max_nx;
  logic signed [7:0] w_min_nx;
  logic [31:0]       w_period;

  assign w_measure   = (r_state == S_MEASURE);
  assign w_gate_last = (r_gate_cnt == GATE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (w_gate_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Next running state, including the sample of the final gate cycle,
  // so results can be captured on the edge that enters DONE.
  always_comb begin
    w_proc     = w_measure && in_valid;
    w_low      = (in_sample <= LO_TH);
    w_high     = (in_sample >= HI_TH);
    w_cross    = w_proc && w_high && r_armed;
    w_cnt_nx   = r_cnt;
    w_armed_nx = r_armed;
    w_last_nx  = r_ts_last;
    w_prev_nx  = r_ts_prev;
    w_nv_nx    = r_ts_nv;
    w_max_nx   = r_max;
    w_min_nx   = r_min;
    if (w_proc && w_low) begin
      w_armed_nx = 1'b1;
    end else if (w_cross) begin
      w_armed_nx = 1'b0;
    end
    if (w_cross) begin
      if (r_cnt != 32'hFFFF_FFFF) begin
        w_cnt_nx = r_cnt + 32'd1;
      end
      w_last_nx = r_gate_cnt;
      w_prev_nx = r_ts_last;
      if (r_ts_nv != 2'd2) begin
        w_nv_nx = r_ts_nv + 2'd1;
      end
    end
    if (w_proc && (in_sample > r_max)) begin
      w_max_nx = in_sample;
    end
    if (w_proc && (in_sample < r_min)) begin
      w_min_nx = in_sample;
    end
    w_period = '0;
    if (w_nv_nx == 2'd2) begin
      w_period = w_last_nx - w_prev_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_cnt <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_ts_last  <= '0;
      r_ts_prev  <= '0;
      r_ts_nv    <= '0;
      r_max      <= MAX_INIT;
      r_min      <= MIN_INIT;
    end else if ((r_state == S_IDLE) && start) begin
      r_gate_cnt <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_ts_last  <= '0;
      r_ts_prev  <= '0;
      r_ts_nv    <= '0;
      r_max      <= MAX_INIT;
      r_min      <= MIN_INIT;
    end else if (w_measure) begin
      r_gate_cnt <= r_gate_cnt + 32'd1;
      r_cnt      <= w_cnt_nx;
      r_armed    <= w_armed_nx;
      r_ts_last  <= w_last_nx;
      r_ts_prev  <= w_prev_nx;
      r_ts_nv    <= w_nv_nx;
      r_max      <= w_max_nx;
      r_min      <= w_min_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crossings   <= '0;
      r_last_period <= '0;
      r_peak_max    <= '0;
      r_peak_min    <= '0;
      r_no_signal   <= 1'b0;
    end else if (w_measure && w_gate_last) begin
      r_crossings   <= w_cnt_nx;
      r_last_period <= w_period;
      r_peak_max    <= w_max_nx;
      r_peak_min    <= w_min_nx;
      r_no_signal   <= (w_cnt_nx < 32'd2);
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign crossings   = r_crossings;
  assign last_period = r_last_period;
  assign peak_max    = r_peak_max;
  assign peak_min    = r_peak_min;
  assign no_signal   = r_no_signal;

endmodule

// File: doc/sine_freq_meter.md
SINE_FREQ_METER -- requirements
Module: sine_freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 1_000_000, SHALL set the measurement window length in clk cycles (legal range 2..2^32-1).
REQ-002 Parameter HYST, default 8, SHALL set the hysteresis threshold magnitude for crossing detection (legal range 1..127).
REQ-003 Port clk, input, 1 bit, SHALL be the clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, asynchronous, active-high.
REQ-005 Port in_valid, input, 1 bit, SHALL mark in_sample as a valid sample for the current cycle.
REQ-006 Port in_sample, input, 8 bits signed two's complement, SHALL carry the sine sample under measurement.
REQ-007 Port start, input, 1 bit, SHALL request a new measurement window.
REQ-008 Port busy, output, 1 bit, SHALL be high while a window is in progress.
REQ-009 Port done, output, 1 bit, SHALL pulse high for exactly one cycle when new results are valid.
REQ-010 Port crossings, output, 32 bits, SHALL give the number of rising crossings detected in the last window.
REQ-011 Port last_period, output, 32 bits, SHALL give the clk-cycle distance between the last two rising crossings of the last window.
REQ-012 Port peak_max and peak_min, outputs, 8 bits signed each, SHALL give the largest and smallest valid sample of the last window.
REQ-013 Port no_signal, output, 1 bit, SHALL be high when the last window had fewer than 2 crossings.

Function
REQ-014 FSM states SHALL be IDLE, MEASURE, DONE.
- IDLE to MEASURE: start=1 in IDLE.
- MEASURE to DONE: the cycle in which gate_cnt equals GATE_CYCLES-1.
- DONE to IDLE: unconditionally after one cycle.
REQ-015 start SHALL be ignored in MEASURE and DONE; no queuing.
REQ-016 On entry to MEASURE, the following SHALL be initialised:
- gate_cnt=0, running count=0, armed_low=0, crossing-timestamp-valid flags cleared;
- running max=-128, running min=+127.
REQ-017 gate_cnt SHALL increment once per clk in MEASURE, independent of in_valid.
REQ-018 Samples SHALL be processed only when in_valid=1 in MEASURE, including the final (GATE_CYCLES-1) cycle.
REQ-019 Hysteresis rules:
- a processed sample <= -HYST SHALL set armed_low;
- a processed sample >= +HYST while armed_low=1 SHALL count one rising crossing and clear armed_low;
- samples strictly between -HYST and +HYST SHALL change nothing.
REQ-020 Each crossing SHALL record the current gate_cnt as its timestamp; last_period SHALL be the final timestamp minus the previous one, or 0 with fewer than 2 crossings.
REQ-021 The running crossing count SHALL saturate at 2^32-1.
REQ-022 Running max and min SHALL update with signed comparison on every processed sample.
REQ-023 In the DONE cycle, crossings, last_period, peak_max, peak_min and no_signal SHALL be registered from running state, with done=1 in that cycle only.
REQ-024 Result outputs SHALL hold their values until the next DONE cycle.
REQ-025 busy SHALL be high in MEASURE and DONE, and low in IDLE.
REQ-026 Latency: done SHALL assert GATE_CYCLES+1 cycles after the cycle in which start was sampled.

Reset
REQ-027 When rst=1, the FSM SHALL go to IDLE and busy, done, crossings, last_period, peak_max, peak_min and no_signal SHALL all be 0, regardless of clk.
REQ-028 rst asserted mid-window SHALL abort the window with no done pulse; results SHALL read 0 until a later window completes.

Verification
REQ-029 GATE_CYCLES=1024, HYST=8, in_valid=1, sample k = 127*sin(2*pi*16k/256) rounded, presented at gate_cnt=k: SHALL give crossings=63, last_period=16, peak_max=127, peak_min=-127, no_signal=0, done pulse 1025 cycles after start.
REQ-030 Constant in_sample=0 for a full window: SHALL give crossings=0, last_period=0, peak_max=0, peak_min=0, no_signal=1.
REQ-031 Square wave alternating +5/-5 every 4 cycles, HYST=8: SHALL give crossings=0 and no_signal=1 (hysteresis rejection); alternating +20/-20 SHALL count every low-to-high transition.
REQ-032 in_valid=0 for the whole window: SHALL give crossings=0, peak_max=-128, peak_min=127.
REQ-033 start re-pulsed at gate_cnt=100, then rst pulsed at gate_cnt=500: SHALL cause no restart at 100, busy=0 and no done after reset, and all results 0.
REQ-034 Back-to-back operation with start=1 held continuously: a new window SHALL begin on the first IDLE cycle after DONE, giving one done pulse every GATE_CYCLES+2 cycles.
